controller_e_md: RTL and testbench

CONTROLLER_E_MD -- requirements
Module: controller_e_md

---
 rtl/controller_e_md.sv | 153 +++++++++++++++
 tb/tb_controller_e_md.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/controller_e_md.sv
// ---------------------------------------------------------------------------
// controller_e_md
// E-stage controller: combinational ALU operand/operation decode plus the
// sequencer for a multi-cycle multiply/divide unit and HI/LO interlock.
//
// Ports
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous active-low reset
//   InstrValidE  in   E stage holds a valid, non-bubble instruction
//   Op, Funct    in   opcode / funct of the E-stage instruction
//   ALUAsrc      out  0 = rs, 1 = shamt
//   ALUBsrc      out  0 = rt, 1 = sext imm, 2 = zext imm, 3 = imm<<16
//   ALUControl   out  ALU operation code (bits above 3 are zero)
//   MDStart      out  one-cycle launch pulse to the mult/div datapath
//   MDOp         out  0 mult, 1 multu, 2 div, 3 divu (valid with MDStart)
//   MDBusy       out  mult/div operation in flight
//   HiLoWe       out  one-cycle pulse writing the mult/div result to HI/LO
//   StallE       out  hold E and earlier, bubble into M
//   HiLoRead     out  0 none, 1 mfhi, 2 mflo
//   HiLoMove     out  0 none, 1 mthi, 2 mtlo
// ---------------------------------------------------------------------------
module controller_e_md #(
    parameter int CTRL_W      = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrValidE,
    input  logic [5:0]        Op,
    input  logic [5:0]        Funct,
    output logic              ALUAsrc,
    output logic [1:0]        ALUBsrc,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              MDStart,
    output logic [1:0]        MDOp,
    output logic              MDBusy,
    output logic              HiLoWe,
    output logic              StallE,
    output logic [1:0]        HiLoRead,
    output logic [1:0]        HiLoMove
);

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd8;

    // Remaining busy cycles; zero means IDLE, non-zero means BUSY.
    logic [5:0] r_count;

    logic       w_asrc;
    logic [1:0] w_bsrc;
    logic [3:0] w_ctrl;
    logic       w_rtype;
    logic       w_md;
    logic       w_hilo_user;
    logic       w_mfhi;
    logic       w_mflo;
    logic       w_mthi;
    logic       w_mtlo;
    logic       w_busy;
    logic       w_issue;

    // ---- combinational decode ----
    always_comb begin
        // Anything not listed falls through to rs/rt with OR.
        w_asrc = 1'b0;
        w_bsrc = 2'd0;
        w_ctrl = ALU_OR;
        case (Op)
            6'b000000: begin
                case (Funct)
                    6'b100001: w_ctrl = ALU_ADD;   // addu
                    6'b100011: w_ctrl = ALU_SUB;   // subu
                    6'b100100: w_ctrl = ALU_AND;   // and
                    6'b100101: w_ctrl = ALU_OR;    // or
                    6'b101010: w_ctrl = ALU_SLT;   // slt
                    6'b101011: w_ctrl = ALU_SLTU;  // sltu
                    6'b000000: begin               // sll
                        w_asrc = 1'b1;
                        w_ctrl = ALU_SLL;
                    end
                    6'b000010: begin               // srl
                        w_asrc = 1'b1;
                        w_ctrl = ALU_SRL;
                    end
                    default: ;
                endcase
            end
            6'b001011: begin w_bsrc = 2'd1; w_ctrl = ALU_SLTU;  end // sltiu
            6'b001101: begin w_bsrc = 2'd2; w_ctrl = ALU_OR;    end // ori
            6'b100011: begin w_bsrc = 2'd1; w_ctrl = ALU_ADD;   end // lw
            6'b101011: begin w_bsrc = 2'd1; w_ctrl = ALU_ADD;   end // sw
            6'b001001: begin w_bsrc = 2'd1; w_ctrl = ALU_ADD;   end // addiu
            6'b001111: begin w_bsrc = 2'd3; w_ctrl = ALU_PASSB; end // lui
            default: ;
        endcase
    end

    always_comb begin
        ALUControl      = '0;
        ALUControl[3:0] = w_ctrl;
    end

    assign ALUAsrc = w_asrc;
    assign ALUBsrc = w_bsrc;

    assign w_rtype     = (Op == 6'b000000);
    // funct 0110xx covers mult/multu/div/divu; low two bits are MDOp.
    assign w_md        = w_rtype && (Funct[5:2] == 4'b0110);
    assign w_mfhi      = w_rtype && (Funct == 6'b010000);
    assign w_mthi      = w_rtype && (Funct == 6'b010001);
    assign w_mflo      = w_rtype && (Funct == 6'b010010);
    assign w_mtlo      = w_rtype && (Funct == 6'b010011);
    assign w_hilo_user = w_md || w_mfhi || w_mthi || w_mflo || w_mtlo;

    // ---- interlock and launch ----
    assign w_busy  = (r_count != 6'd0);
    assign StallE  = InstrValidE && w_hilo_user && w_busy;
    // StallE implies busy, so a launch can only happen from IDLE.
    assign w_issue = InstrValidE && !StallE;

    assign MDBusy  = w_busy;
    assign MDStart = w_issue && w_md;
    assign MDOp    = MDStart ? Funct[1:0] : 2'd0;
    // Final busy cycle carries the result write.
    assign HiLoWe  = (r_count == 6'd1);

    assign HiLoRead = !w_issue ? 2'd0 :
                      w_mfhi   ? 2'd1 :
                      w_mflo   ? 2'd2 : 2'd0;
    assign HiLoMove = !w_issue ? 2'd0 :
                      w_mthi   ? 2'd1 :
                      w_mtlo   ? 2'd2 : 2'd0;

    // ---- busy counter: only reset can abort an in-flight operation ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 6'd0;
        end else if (MDStart) begin
            r_count <= Funct[1] ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
        end else if (w_busy) begin
            r_count <= r_count - 6'd1;
        end
    end

endmodule

// File: tb/tb_controller_e_md.sv
module tb_controller_e_md;

    logic       clk;
    logic       reset;
    logic       InstrValidE;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       ALUAsrc;
    logic [1:0] ALUBsrc;
    logic [3:0] ALUControl;
    logic       MDStart;
    logic [1:0] MDOp;
    logic       MDBusy;
    logic       HiLoWe;
    logic       StallE;
    logic [1:0] HiLoRead;
    logic [1:0] HiLoMove;

    int n_chk = 0;
    int n_err = 0;

    controller_e_md #(.CTRL_W(4), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .InstrValidE(InstrValidE), .Op(Op), .Funct(Funct),
        .ALUAsrc(ALUAsrc), .ALUBsrc(ALUBsrc), .ALUControl(ALUControl),
        .MDStart(MDStart), .MDOp(MDOp), .MDBusy(MDBusy), .HiLoWe(HiLoWe),
        .StallE(StallE), .HiLoRead(HiLoRead), .HiLoMove(HiLoMove)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs one time unit after a rising edge, let comb logic settle.
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
        InstrValidE = v;
        Op          = op;
        Funct       = fn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic a, input logic [1:0] b, input logic [3:0] c);
        chk({tag, ".Asrc"}, 32'(ALUAsrc), 32'(a));
        chk({tag, ".Bsrc"}, 32'(ALUBsrc), 32'(b));
        chk({tag, ".Ctrl"}, 32'(ALUControl), 32'(c));
    endtask

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    int we_cnt;

    initial begin
        reset = 1'b0;
        drive(1'b0, 6'd0, 6'd0);
        tick();
        tick();
        chk("rst.MDBusy", 32'(MDBusy), 32'd0);
        chk("rst.HiLoWe", 32'(HiLoWe), 32'd0);
        chk("rst.StallE", 32'(StallE), 32'd0);
        reset = 1'b1;
        tick();

        // Decode spot checks
        drive(1'b1, 6'b001101, 6'd0);  chk_dec("ori",  1'b0, 2'd2, 4'd1);
        drive(1'b1, 6'b001111, 6'd0);  chk_dec("lui",  1'b0, 2'd3, 4'd8);
        drive(1'b1, 6'b000000, 6'd0);  chk_dec("sll",  1'b1, 2'd0, 4'd4);
        drive(1'b1, 6'b001011, 6'd0);  chk_dec("sltiu",1'b0, 2'd1, 4'd6);
        drive(1'b1, 6'b000000, 6'b000010); chk_dec("srl", 1'b1, 2'd0, 4'd5);
        drive(1'b1, 6'b000000, 6'b101010); chk_dec("slt", 1'b0, 2'd0, 4'd7);
        drive(1'b1, 6'b000000, 6'b100011); chk_dec("subu",1'b0, 2'd0, 4'd3);
        drive(1'b1, 6'b000000, 6'b100100); chk_dec("and", 1'b0, 2'd0, 4'd0);

        // Undecoded instructions
        drive(1'b1, 6'b111111, 6'd0);
        chk_dec("badop", 1'b0, 2'd0, 4'd1);
        chk("badop.MDStart", 32'(MDStart), 32'd0);
        chk("badop.StallE",  32'(StallE),  32'd0);
        drive(1'b1, 6'b000000, 6'b111111);
        chk_dec("badfn", 1'b0, 2'd0, 4'd1);
        chk("badfn.MDStart", 32'(MDStart), 32'd0);
        chk("badfn.StallE",  32'(StallE),  32'd0);
        chk("badfn.HiLoRead",32'(HiLoRead),32'd0);

        // mult timing: start cycle 0, busy 1..5, HiLoWe at 5, idle at 6
        drive(1'b1, 6'd0, F_MULT);
        chk("mult.MDStart", 32'(MDStart), 32'd1);
        chk("mult.MDOp",    32'(MDOp),    32'd0);
        chk("mult.StallE",  32'(StallE),  32'd0);
        chk("mult.MDBusy0", 32'(MDBusy),  32'd0);
        tick();
        drive(1'b0, 6'd0, F_MULT);
        chk("mult.bubbleStart", 32'(MDStart), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("mult.MDBusy%0d", c), 32'(MDBusy), 32'd1);
            chk($sformatf("mult.HiLoWe%0d", c), 32'(HiLoWe), (c == 5) ? 32'd1 : 32'd0);
            tick();
        end
        chk("mult.MDBusy6", 32'(MDBusy), 32'd0);
        chk("mult.HiLoWe6", 32'(HiLoWe), 32'd0);

        // divu then mflo: stall cycles 1..10, read at 11
        drive(1'b1, 6'd0, F_DIVU);
        chk("divu.MDStart", 32'(MDStart), 32'd1);
        chk("divu.MDOp",    32'(MDOp),    32'd3);
        tick();
        drive(1'b1, 6'd0, F_MFLO);
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("mflo.StallE%0d", c),   32'(StallE),   32'd1);
            chk($sformatf("mflo.HiLoRead%0d", c), 32'(HiLoRead), 32'd0);
            chk($sformatf("mflo.MDStart%0d", c),  32'(MDStart),  32'd0);
            tick();
        end
        chk("mflo.StallE11",   32'(StallE),   32'd0);
        chk("mflo.HiLoRead11", 32'(HiLoRead), 32'd2);
        chk("mflo.MDBusy11",   32'(MDBusy),   32'd0);
        tick();

        // mult then ALU instructions during busy never stall
        drive(1'b1, 6'd0, F_MULT);
        chk("mult2.MDStart", 32'(MDStart), 32'd1);
        tick();
        drive(1'b1, 6'd0, 6'b100001);
        chk_dec("addu", 1'b0, 2'd0, 4'd2);
        chk("addu.StallE", 32'(StallE), 32'd0);
        chk("addu.MDBusy", 32'(MDBusy), 32'd1);
        tick();
        drive(1'b1, 6'b001101, 6'd0);
        chk_dec("ori2", 1'b0, 2'd2, 4'd1);
        chk("ori2.StallE", 32'(StallE), 32'd0);
        tick();
        drive(1'b1, 6'b100011, 6'd0);
        chk_dec("lw", 1'b0, 2'd1, 4'd2);
        chk("lw.StallE", 32'(StallE), 32'd0);
        tick();
        // cycle 4: mthi stalls while busy
        drive(1'b1, 6'd0, F_MTHI);
        chk("mthi.StallE",   32'(StallE),   32'd1);
        chk("mthi.HiLoMove", 32'(HiLoMove), 32'd0);
        tick();
        // cycle 5 (count 1): back-to-back multu stalls one cycle
        drive(1'b1, 6'd0, F_MULTU);
        chk("b2b.HiLoWe",  32'(HiLoWe),  32'd1);
        chk("b2b.StallE",  32'(StallE),  32'd1);
        chk("b2b.MDStart", 32'(MDStart), 32'd0);
        tick();
        chk("b2b.StallE6",  32'(StallE),  32'd0);
        chk("b2b.MDStart6", 32'(MDStart), 32'd1);
        chk("b2b.MDOp6",    32'(MDOp),    32'd1);
        chk("b2b.HiLoWe6",  32'(HiLoWe),  32'd0);
        tick();
        drive(1'b0, 6'd0, 6'd0);
        we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (HiLoWe) we_cnt++;
            tick();
        end
        chk("b2b.WePulses", 32'(we_cnt), 32'd1);
        chk("b2b.idle",     32'(MDBusy), 32'd0);
        drive(1'b1, 6'd0, F_MTLO);
        chk("mtlo.HiLoMove", 32'(HiLoMove), 32'd2);
        chk("mtlo.StallE",   32'(StallE),   32'd0);
        tick();

        // div aborted by reset at cycle 4; multu at cycle 6 issues
        drive(1'b1, 6'd0, F_DIV);
        chk("div.MDStart", 32'(MDStart), 32'd1);
        chk("div.MDOp",    32'(MDOp),    32'd2);
        tick();
        drive(1'b0, 6'd0, 6'd0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("abort.busy4", 32'(MDBusy), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("abort.MDBusy5", 32'(MDBusy), 32'd0);
        chk("abort.HiLoWe5", 32'(HiLoWe), 32'd0);
        tick();
        drive(1'b1, 6'd0, F_MULTU);
        chk("post.MDStart", 32'(MDStart), 32'd1);
        chk("post.MDOp",    32'(MDOp),    32'd1);
        tick();
        drive(1'b0, 6'd0, 6'd0);
        we_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            if (HiLoWe) we_cnt++;
            tick();
        end
        chk("post.WePulses", 32'(we_cnt), 32'd1);
        chk("post.idle",     32'(MDBusy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
